// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multicycle RV32I main controller.
// Holds the FSM state encoding, the RV32I major opcodes, the ALU operation
// encoding and the datapath mux / immediate-type select values.
package control_pkg;

  localparam int WORD_SIZE = 32;
  localparam int STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_AUIPC,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP,
    S_EXEC_JALR,
    S_HALT
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU operation encoding
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // Memory address source
  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_BUS = 1'b1;

  // Output bus source
  localparam logic [2:0] OUT_ALU_REG  = 3'd0;
  localparam logic [2:0] OUT_ALU_OUT  = 3'd1;
  localparam logic [2:0] OUT_DATA_REG = 3'd2;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // ALU operand sources
  localparam logic [1:0] SRC_A_OLD_PC = 2'd0;
  localparam logic [1:0] SRC_A_PC     = 2'd1;
  localparam logic [1:0] SRC_A_REG    = 2'd2;
  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_FOUR   = 2'd2;

  // funct3 010/011 has no branch meaning in RV32I.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  // Branch decision from the compare flags produced during BRANCH.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       lt);
    logic t;
    case (f3)
      3'b000:  t = zero;          // BEQ
      3'b001:  t = !zero;         // BNE
      3'b100,
      3'b110:  t = lt;            // BLT / BLTU
      3'b101,
      3'b111:  t = !lt;           // BGE / BGEU
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: maps {funct3, funct7[5]} to the ALU operation for the
// register-register (EXEC_R) and register-immediate (EXEC_I) paths.
//   funct3     : IR[14:12]
//   funct7_b5  : IR[30]
//   is_reg_op  : 1 for OP, 0 for OP-IMM
//   alu_ctrl   : ALU operation (control_pkg encoding)
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_reg_op,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      // IR[30] in ADDI is part of the immediate, so SUB only exists for OP.
      3'b000: alu_ctrl = (is_reg_op && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_ctrl = ALU_SLL;
      3'b010: alu_ctrl = ALU_SLT;
      3'b011: alu_ctrl = ALU_SLTU;
      3'b100: alu_ctrl = ALU_XOR;
      // SRA/SRAI share the funct7[5] marker in both formats.
      3'b101: alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_ctrl = ALU_OR;
      3'b111: alu_ctrl = ALU_AND;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle Moore controller for the shared-bus RV32I datapath.
// Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK; one instruction in
// flight at a time, 3..5 cycles each.
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   opcode/funct3/7   : instruction register fields (stable after FETCH)
//   zero_flag, alu_lt : ALU compare flags, consumed in BRANCH
//   adr_src..alu_ctrl : datapath selects and write enables
//   halted, illegal   : FSM is in HALT / HALT reached via an undecodable opcode
//   state_dbg         : current FSM state, for observation only
module control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  input  logic       alu_lt,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic [1:0] mem_ctrl,
  output logic       reg_write,
  output logic       output_en,
  output logic [2:0] out_mux_sel,
  output logic [2:0] imm_extend_sel,
  output logic [2:0] load_extend_sel,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       halted,
  output logic       illegal,
  output state_t     state_dbg
);

  state_t     state, next_state;
  logic       illegal_q;
  logic       set_illegal;
  logic [3:0] dec_alu_ctrl;
  logic       pc_write_raw, ir_write_raw, mem_write_raw;
  logic       reg_write_raw, output_en_raw;

  // Only funct7[5] carries meaning for RV32I base ALU ops.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  alu_decoder u_alu_decoder (
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .is_reg_op (state == S_EXEC_R),
    .alu_ctrl  (dec_alu_ctrl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state      = state;
    set_illegal     = 1'b0;
    adr_src         = ADR_PC;
    pc_write_raw    = 1'b0;
    ir_write_raw    = 1'b0;
    mem_write_raw   = 1'b0;
    mem_ctrl        = 2'd0;
    reg_write_raw   = 1'b0;
    output_en_raw   = 1'b0;
    out_mux_sel     = OUT_ALU_REG;
    imm_extend_sel  = IMM_I;
    load_extend_sel = 3'd0;
    alu_src_a_sel   = SRC_A_OLD_PC;
    alu_src_b_sel   = SRC_B_REG;
    alu_ctrl        = ALU_ADD;

    case (state)
      S_FETCH: begin
        // IR <= mem[PC]; PC <= PC + 4 through alu_out.
        ir_write_raw  = 1'b1;
        alu_src_a_sel = SRC_A_PC;
        alu_src_b_sel = SRC_B_FOUR;
        out_mux_sel   = OUT_ALU_OUT;
        pc_write_raw  = 1'b1;
        next_state    = S_DECODE;
      end
      S_DECODE: begin
        // old PC + imm lands in alu_reg as a speculative branch/jump target.
        alu_src_a_sel = SRC_A_OLD_PC;
        alu_src_b_sel = SRC_B_IMM;
        if (opcode == OPC_BRANCH)   imm_extend_sel = IMM_B;
        else if (opcode == OPC_JAL) imm_extend_sel = IMM_J;
        case (opcode)
          OPC_LOAD, OPC_STORE: next_state = S_MEM_ADR;
          OPC_OP:              next_state = S_EXEC_R;
          OPC_OP_IMM:          next_state = S_EXEC_I;
          OPC_BRANCH:          next_state = S_BRANCH;
          OPC_JAL:             next_state = S_JUMP;
          OPC_JALR:            next_state = S_EXEC_JALR;
          OPC_LUI:             next_state = S_LUI;
          OPC_AUIPC:           next_state = S_AUIPC;
          default: begin
            next_state  = S_HALT;
            set_illegal = (opcode != OPC_SYSTEM);
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_sel  = SRC_A_REG;
        alu_src_b_sel  = SRC_B_IMM;
        imm_extend_sel = (opcode == OPC_LOAD) ? IMM_I : IMM_S;
        next_state     = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src         = ADR_BUS;
        out_mux_sel     = OUT_ALU_REG;
        mem_ctrl        = funct3[1:0];
        load_extend_sel = funct3;
        next_state      = S_MEM_WB;
      end
      S_MEM_WB: begin
        out_mux_sel     = OUT_DATA_REG;
        reg_write_raw   = 1'b1;
        output_en_raw   = 1'b1;
        load_extend_sel = funct3;
        next_state      = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src       = ADR_BUS;
        out_mux_sel   = OUT_ALU_REG;
        mem_write_raw = 1'b1;
        mem_ctrl      = funct3[1:0];
        next_state    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_sel = SRC_A_REG;
        alu_src_b_sel = SRC_B_REG;
        alu_ctrl      = dec_alu_ctrl;
        next_state    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_sel  = SRC_A_REG;
        alu_src_b_sel  = SRC_B_IMM;
        imm_extend_sel = IMM_I;
        alu_ctrl       = dec_alu_ctrl;
        next_state     = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b_sel  = SRC_B_IMM;
        imm_extend_sel = IMM_U;
        alu_ctrl       = ALU_PASS_B;
        next_state     = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a_sel  = SRC_A_OLD_PC;
        alu_src_b_sel  = SRC_B_IMM;
        imm_extend_sel = IMM_U;
        alu_ctrl       = ALU_ADD;
        next_state     = S_ALU_WB;
      end
      S_ALU_WB: begin
        out_mux_sel   = OUT_ALU_REG;
        reg_write_raw = 1'b1;
        output_en_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_sel = SRC_A_REG;
        alu_src_b_sel = SRC_B_REG;
        case (funct3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          3'b110, 3'b111: alu_ctrl = ALU_SLTU;
          default:        alu_ctrl = ALU_ADD;
        endcase
        if (!branch_f3_legal(funct3)) begin
          next_state  = S_HALT;
          set_illegal = 1'b1;
        end else begin
          // Target computed in DECODE is already waiting in alu_reg.
          if (branch_taken(funct3, zero_flag, alu_lt)) begin
            out_mux_sel  = OUT_ALU_REG;
            pc_write_raw = 1'b1;
          end
          next_state = S_FETCH;
        end
      end
      S_JUMP: begin
        // PC <= alu_reg (target) while the ALU forms old PC + 4 as the
        // return address, which ALU_WB then writes back.
        out_mux_sel   = OUT_ALU_REG;
        pc_write_raw  = 1'b1;
        alu_src_a_sel = SRC_A_OLD_PC;
        alu_src_b_sel = SRC_B_FOUR;
        alu_ctrl      = ALU_ADD;
        next_state    = S_ALU_WB;
      end
      S_EXEC_JALR: begin
        // rs1 + imm; bit 0 is deliberately not cleared.
        alu_src_a_sel  = SRC_A_REG;
        alu_src_b_sel  = SRC_B_IMM;
        imm_extend_sel = IMM_I;
        alu_ctrl       = ALU_ADD;
        next_state     = S_JUMP;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Enables are qualified by rst so FETCH's writes stay off while reset is
  // held and nothing is written after rst falls mid-instruction.
  assign pc_write  = pc_write_raw  & rst;
  assign ir_write  = ir_write_raw  & rst;
  assign mem_write = mem_write_raw & rst;
  assign reg_write = reg_write_raw & rst;
  assign output_en = output_en_raw & rst;
  assign halted    = (state == S_HALT);
  assign illegal   = illegal_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed-vector bench for control_fsm. Each cycle the
// observed control bundle and state are compared with hand-computed values.
module tb_control_fsm;
  import control_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero_flag = 1'b0;
  logic       alu_lt = 1'b0;

  logic       adr_src, pc_write, ir_write, mem_write, reg_write, output_en;
  logic [1:0] mem_ctrl, alu_src_a_sel, alu_src_b_sel;
  logic [2:0] out_mux_sel, imm_extend_sel, load_extend_sel;
  logic [3:0] alu_ctrl;
  logic       halted, illegal;
  state_t     state_dbg;

  control_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .zero_flag       (zero_flag),
    .alu_lt          (alu_lt),
    .adr_src         (adr_src),
    .pc_write        (pc_write),
    .ir_write        (ir_write),
    .mem_write       (mem_write),
    .mem_ctrl        (mem_ctrl),
    .reg_write       (reg_write),
    .output_en       (output_en),
    .out_mux_sel     (out_mux_sel),
    .imm_extend_sel  (imm_extend_sel),
    .load_extend_sel (load_extend_sel),
    .alu_src_a_sel   (alu_src_a_sel),
    .alu_src_b_sel   (alu_src_b_sel),
    .alu_ctrl        (alu_ctrl),
    .halted          (halted),
    .illegal         (illegal),
    .state_dbg       (state_dbg)
  );

  logic [26:0] obs;
  assign obs = {adr_src, pc_write, ir_write, mem_write, mem_ctrl, reg_write,
                output_en, out_mux_sel, imm_extend_sel, load_extend_sel,
                alu_src_a_sel, alu_src_b_sel, alu_ctrl, halted, illegal};

  int total = 0;
  int bad   = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected bundle, argument order matches obs.
  function automatic logic [26:0] ctl(
    input logic adr, input logic pcw, input logic irw, input logic mw,
    input logic [1:0] mc, input logic rw, input logic oe,
    input logic [2:0] om, input logic [2:0] im, input logic [2:0] le,
    input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
    input logic hlt, input logic ill);
    return {adr, pcw, irw, mw, mc, rw, oe, om, im, le, sa, sb, alu, hlt, ill};
  endfunction

  logic [26:0] v_fetch, v_alu_wb;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Check the current cycle, then advance one clock.
  task automatic expect_cycle(input string tag, input state_t st,
                              input logic [26:0] v);
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
    chk({tag, "_ctl"}, 32'(obs), 32'(v));
    tick();
  endtask

  // Mid-cycle asynchronous reset pulse; starts and ends between edges.
  task automatic rst_pulse(input string tag);
    #3 rst = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state_dbg), 32'(S_FETCH));
    chk({tag, "_en"}, {27'd0, pc_write, ir_write, mem_write, reg_write,
                       output_en}, 32'd0);
    chk({tag, "_hi"}, {30'd0, halted, illegal}, 32'd0);
    #1 rst = 1'b1;
    #1;
  endtask

  initial begin
    v_fetch  = ctl(0,1,1,0,2'd0,0,0,3'd1,3'd0,3'd0,2'd1,2'd2,4'd0,0,0);
    v_alu_wb = ctl(0,0,0,0,2'd0,1,1,3'd0,3'd0,3'd0,2'd0,2'd0,4'd0,0,0);

    // Reset held three cycles with a decodable instruction present.
    set_ir(OPC_OP, 3'b000, 7'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
      chk("rst_en", {27'd0, pc_write, ir_write, mem_write, reg_write,
                     output_en}, 32'd0);
      chk("rst_hi", {30'd0, halted, illegal}, 32'd0);
    end
    #2 rst = 1'b1;
    #1;

    // ADD x3,x1,x2
    expect_cycle("add_f", S_FETCH, v_fetch);
    expect_cycle("add_d", S_DECODE,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd1,4'd0,0,0));
    expect_cycle("add_x", S_EXEC_R,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd0,0,0));
    expect_cycle("add_wb", S_ALU_WB, v_alu_wb);

    // SUB
    set_ir(OPC_OP, 3'b000, 7'b0100000);
    expect_cycle("sub_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("sub_x", S_EXEC_R,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd1,0,0));
    expect_cycle("sub_wb", S_ALU_WB, v_alu_wb);

    // ADDI with IR[30] set must still be ADD
    set_ir(OPC_OP_IMM, 3'b000, 7'b0100000);
    expect_cycle("addi_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("addi_x", S_EXEC_I,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd1,4'd0,0,0));
    expect_cycle("addi_wb", S_ALU_WB, v_alu_wb);

    // SRAI
    set_ir(OPC_OP_IMM, 3'b101, 7'b0100000);
    expect_cycle("srai_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("srai_x", S_EXEC_I,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd1,4'd7,0,0));
    expect_cycle("srai_wb", S_ALU_WB, v_alu_wb);

    // LW: 5 cycles
    set_ir(OPC_LOAD, 3'b010, 7'd0);
    expect_cycle("lw_f", S_FETCH, v_fetch);
    expect_cycle("lw_d", S_DECODE,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd1,4'd0,0,0));
    expect_cycle("lw_a", S_MEM_ADR,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd1,4'd0,0,0));
    expect_cycle("lw_r", S_MEM_READ,
                 ctl(1,0,0,0,2'd2,0,0,3'd0,3'd0,3'd2,2'd0,2'd0,4'd0,0,0));
    expect_cycle("lw_wb", S_MEM_WB,
                 ctl(0,0,0,0,2'd0,1,1,3'd2,3'd0,3'd2,2'd0,2'd0,4'd0,0,0));

    // SH: 4 cycles
    set_ir(OPC_STORE, 3'b001, 7'd0);
    expect_cycle("sh_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("sh_a", S_MEM_ADR,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd1,3'd0,2'd2,2'd1,4'd0,0,0));
    expect_cycle("sh_w", S_MEM_WRITE,
                 ctl(1,0,0,1,2'd1,0,0,3'd0,3'd0,3'd0,2'd0,2'd0,4'd0,0,0));

    // BEQ taken
    set_ir(OPC_BRANCH, 3'b000, 7'd0);
    zero_flag = 1'b1;
    expect_cycle("beq_f", S_FETCH, v_fetch);
    expect_cycle("beq_d", S_DECODE,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd2,3'd0,2'd0,2'd1,4'd0,0,0));
    expect_cycle("beq_b", S_BRANCH,
                 ctl(0,1,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd1,0,0));
    zero_flag = 1'b0;

    // BGEU with alu_lt=1: not taken
    set_ir(OPC_BRANCH, 3'b111, 7'd0);
    alu_lt = 1'b1;
    expect_cycle("bgeu_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("bgeu_b", S_BRANCH,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd9,0,0));

    // BLT with alu_lt=1: taken
    set_ir(OPC_BRANCH, 3'b100, 7'd0);
    expect_cycle("blt_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("blt_b", S_BRANCH,
                 ctl(0,1,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd8,0,0));
    alu_lt = 1'b0;

    // JAL: 4 cycles
    set_ir(OPC_JAL, 3'b000, 7'd0);
    expect_cycle("jal_f", S_FETCH, v_fetch);
    expect_cycle("jal_d", S_DECODE,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd4,3'd0,2'd0,2'd1,4'd0,0,0));
    expect_cycle("jal_j", S_JUMP,
                 ctl(0,1,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd2,4'd0,0,0));
    expect_cycle("jal_wb", S_ALU_WB, v_alu_wb);

    // JALR: 5 cycles
    set_ir(OPC_JALR, 3'b000, 7'd0);
    expect_cycle("jalr_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("jalr_x", S_EXEC_JALR,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd1,4'd0,0,0));
    expect_cycle("jalr_j", S_JUMP,
                 ctl(0,1,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd2,4'd0,0,0));
    expect_cycle("jalr_wb", S_ALU_WB, v_alu_wb);

    // LUI
    set_ir(OPC_LUI, 3'b000, 7'd0);
    expect_cycle("lui_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("lui_x", S_LUI,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd3,3'd0,2'd0,2'd1,4'd10,0,0));
    expect_cycle("lui_wb", S_ALU_WB, v_alu_wb);

    // AUIPC
    set_ir(OPC_AUIPC, 3'b000, 7'd0);
    expect_cycle("auipc_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("auipc_x", S_AUIPC,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd3,3'd0,2'd0,2'd1,4'd0,0,0));
    expect_cycle("auipc_wb", S_ALU_WB, v_alu_wb);

    // Store aborted by reset while MEM_WRITE is active
    set_ir(OPC_STORE, 3'b010, 7'd0);
    expect_cycle("swab_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("swab_a", S_MEM_ADR,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd1,3'd0,2'd2,2'd1,4'd0,0,0));
    rst_pulse("swab_rst");

    // Undecodable opcode -> HALT with illegal, terminal for 10 cycles
    set_ir(7'b1111111, 3'b000, 7'd0);
    expect_cycle("ill_f", S_FETCH, v_fetch);
    expect_cycle("ill_d", S_DECODE,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd1,4'd0,0,0));
    for (int i = 0; i < 10; i++)
      expect_cycle("ill_h", S_HALT,
                   ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd0,4'd0,1,1));
    rst_pulse("ill_rst");

    // SYSTEM -> HALT without illegal
    set_ir(OPC_SYSTEM, 3'b000, 7'd0);
    expect_cycle("sys_f", S_FETCH, v_fetch);
    tick();
    for (int i = 0; i < 2; i++)
      expect_cycle("sys_h", S_HALT,
                   ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd0,4'd0,1,0));
    rst_pulse("sys_rst");

    // Branch funct3 010 -> HALT with illegal
    set_ir(OPC_BRANCH, 3'b010, 7'd0);
    zero_flag = 1'b1;
    alu_lt = 1'b1;
    expect_cycle("bill_f", S_FETCH, v_fetch);
    tick();
    expect_cycle("bill_b", S_BRANCH,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd2,2'd0,4'd0,0,0));
    expect_cycle("bill_h", S_HALT,
                 ctl(0,0,0,0,2'd0,0,0,3'd0,3'd0,3'd0,2'd0,2'd0,4'd0,1,1));
    rst_pulse("bill_rst");
    expect_cycle("post_f", S_FETCH, v_fetch);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
